// File: rtl/counter_sequencer.sv
// Mode sequencer for a 4-bit counter: conditions the switch and button inputs, then drives the
// counter's clear/enable from a small FSM (hold, free-run, single-step, seek-to-target).
module counter_sequencer #(
  parameter int unsigned PRESCALE        = 12500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter logic [3:0]  TARGET          = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] switches,
  input  logic       btn,
  input  logic [3:0] counter_in,
  output logic       cnt_rst,
  output logic       cnt_en,
  output logic [3:0] leds,
  output logic       done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DbMax    = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] StClear = 3'd0;
  localparam logic [2:0] StHold  = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StStep  = 3'd3;
  localparam logic [2:0] StSeek  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [1:0]    sw_meta, sw_sync;
  logic          btn_meta, btn_sync, btn_db, btn_db_prev;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] presc;
  logic [2:0]    state, state_next;
  logic [1:0]    mode, mode_next;
  logic          en_next;
  logic          press, tick, keep_counting;

  assign press = btn_db & ~btn_db_prev;
  assign tick  = ((state == StRun) || (state == StSeek)) && (presc == PrescMax);
  // Prescaler only survives a cycle that stays in RUN/SEEK, so every entry starts from zero.
  assign keep_counting = ((state_next == StRun) || (state_next == StSeek)) &&
                         (state_next == state);

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta     <= 2'b00;
      sw_sync     <= 2'b00;
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_db      <= 1'b0;
      btn_db_prev <= 1'b0;
      db_cnt      <= '0;
    end else begin
      sw_meta     <= switches;
      sw_sync     <= sw_meta;
      btn_meta    <= btn;
      btn_sync    <= btn_meta;
      btn_db_prev <= btn_db;
      // Any sample matching the accepted level restarts the stability count.
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DbMax) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    mode_next  = mode;
    en_next    = 1'b0;
    case (state)
      StClear: begin
        mode_next = sw_sync;
        unique case (sw_sync)
          2'b00: state_next = StHold;
          2'b01: state_next = StRun;
          2'b10: state_next = StStep;
          2'b11: state_next = StSeek;
        endcase
      end
      StHold: state_next = StHold;
      StRun: begin
        if (press) state_next = StClear;
        else if (tick) en_next = 1'b1;
      end
      StStep: begin
        if (press) en_next = 1'b1;
      end
      StSeek: begin
        if (tick) begin
          if (counter_in == TARGET) state_next = StDone;
          else en_next = 1'b1;
        end
      end
      StDone: begin
        if (press) state_next = StClear;
      end
      default: state_next = StClear;
    endcase
    if ((state != StClear) && (sw_sync != mode)) begin
      state_next = StClear;
      en_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StClear;
      mode    <= 2'b00;
      presc   <= '0;
      cnt_rst <= 1'b1;
      cnt_en  <= 1'b0;
      leds    <= 4'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      mode    <= mode_next;
      presc   <= (keep_counting && !tick) ? presc + PW'(1) : '0;
      cnt_rst <= (state_next == StClear);
      cnt_en  <= en_next;
      leds    <= counter_in;
      done    <= (state_next == StDone);
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: predicted clear/enable pulses (with their cycle) are queued by the
// stimulus and checked by an independent monitor against a simple 4-bit counter model.
module tb_counter_sequencer;

  localparam int unsigned P        = 4;
  localparam int unsigned D        = 3;
  localparam int unsigned T        = 5;
  localparam int unsigned PressLat = 2 + D + 1;
  localparam int unsigned SwLat    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] switches;
  logic       btn;
  logic [3:0] counter_in;
  logic       cnt_rst, cnt_en, done;
  logic [3:0] leds;
  logic [3:0] cnt_model = 4'd0;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    bit          is_rst;
    int unsigned at;
  } ev_t;
  ev_t exp_q[$];
  ev_t ev;

  bit         mon_on = 1'b0;
  bit         have_prev = 1'b0;
  bit         rst_prev = 1'b0;
  logic [3:0] prev_cnt = 4'd0;

  counter_sequencer #(
    .PRESCALE       (P),
    .DEBOUNCE_CYCLES(D),
    .TARGET         (4'(T))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .switches  (switches),
    .btn       (btn),
    .counter_in(counter_in),
    .cnt_rst   (cnt_rst),
    .cnt_en    (cnt_en),
    .leds      (leds),
    .done      (done)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controlled counter: sync clear, increment on enable, natural 4-bit wrap.
  always @(posedge clk) begin
    if (cnt_rst) cnt_model <= 4'd0;
    else if (cnt_en) cnt_model <= cnt_model + 4'd1;
  end
  assign counter_in = cnt_model;

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: cyc=%0d got %0d want %0d", name, cyc, got, want);
    end
  endtask

  function automatic void push(input bit is_rst, input int unsigned at);
    ev_t e;
    e.is_rst = is_rst;
    e.at     = at;
    exp_q.push_back(e);
  endfunction

  // Enable pulses of a prescaled state entered at `entry`, up to and including edge `last`.
  function automatic void push_ticks(input int unsigned entry, input int unsigned last);
    for (int unsigned t = entry + P; t <= last; t += P) push(1'b0, t);
  endfunction

  // Seek from a cleared counter: TARGET pulses, returns the edge at which done rises.
  function automatic int unsigned push_seek(input int unsigned entry);
    for (int unsigned k = 1; k <= T; k++) push(1'b0, entry + P * k);
    return entry + P * (T + 1);
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (cnt_en || cnt_rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: cyc=%0d en=%0b rst=%0b, none expected", cyc, cnt_en,
                   cnt_rst);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind", {30'd0, cnt_rst, cnt_en}, ev.is_rst ? 32'd2 : 32'd1);
          check("pulse_cycle", cyc, ev.at);
        end
      end
      if (have_prev) check("leds", 32'(leds), rst_prev ? 32'd0 : 32'(prev_cnt));
      prev_cnt  = cnt_model;
      rst_prev  = rst;
      have_prev = 1'b1;
    end
  end

  task automatic go(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic press_clean();
    btn = 1'b1;
    go(8);
    btn = 1'b0;
    go(8);
  endtask

  task automatic glitch();
    btn = 1'b1;
    go(2);
    btn = 1'b0;
    go(8);
  endtask

  initial begin
    int unsigned e, n, p, b, m, d, k, g;
    rst = 1'b1;
    switches = 2'b01;
    btn = 1'b0;
    go(3);
    rst = 1'b0;
    mon_on = 1'b1;

    // Reset edge 3 clears; synced switches leave 00 two cycles later, forcing one more clear.
    push(1'b1, 3);
    push(1'b1, 6);
    e = 7;
    n = e + 23 * P + 1 + $urandom_range(0, 3);
    push_ticks(e, n + 2);
    push(1'b1, n + SwLat);
    go(e + 15 * P + 1 - cyc);
    check("run_at_15", 32'(cnt_model), 15);
    go(P);
    check("run_wrapped", 32'(cnt_model), 0);
    go(n - cyc);
    check("run_at_7", 32'(cnt_model), 7);
    switches = 2'b00;
    go(SwLat + 2);
    check("hold_cleared", 32'(cnt_model), 0);
    press_clean();
    check("hold_press_ignored", 32'(cnt_model), 0);
    check("hold_not_done", 32'(done), 0);

    // Single-step with a short glitch slipped in among clean presses.
    n = cyc;
    switches = 2'b10;
    push(1'b1, n + SwLat);
    go(SwLat + 3);
    k = $urandom_range(3, 5);
    g = $urandom_range(0, k - 1);
    for (int unsigned i = 0; i < k; i++) begin
      if (i == g) glitch();
      go($urandom_range(0, 4));
      push(1'b0, cyc + PressLat);
      press_clean();
    end
    check("step_count", 32'(cnt_model), k);

    // Seek to target, then restart with a press.
    n = cyc;
    switches = 2'b11;
    push(1'b1, n + SwLat);
    e = n + SwLat + 1;
    d = push_seek(e);
    go(d - 1 - cyc);
    check("seek_not_early", 32'(done), 0);
    go(1);
    check("seek_done", 32'(done), 1);
    check("seek_target", 32'(cnt_model), T);
    go(50);
    check("done_held_cnt", 32'(cnt_model), T);
    check("done_stays", 32'(done), 1);

    p = cyc;
    push(1'b1, p + PressLat);
    e = p + PressLat + 1;
    n = e + 3 * P + 1 + $urandom_range(0, 2);
    push_ticks(e, n);
    push(1'b1, n + 1);
    push(1'b1, n + 4);
    d = push_seek(n + 5);
    btn = 1'b1;
    go(PressLat);
    check("restart_clear", 32'(cnt_rst), 1);
    check("restart_done_low", 32'(done), 0);
    go(2);
    btn = 1'b0;
    go(n - cyc);
    check("seek_at_3", 32'(cnt_model), 3);
    rst = 1'b1;
    go(1);
    rst = 1'b0;
    check("rst_en_low", 32'(cnt_en), 0);
    check("rst_done_low", 32'(done), 0);
    check("rst_clear", 32'(cnt_rst), 1);
    go(d - cyc);
    check("reseek_done", 32'(done), 1);
    check("reseek_target", 32'(cnt_model), T);

    // Bouncy press in run mode: exactly one restart once the level settles.
    n = cyc;
    switches = 2'b01;
    push(1'b1, n + SwLat);
    e = n + SwLat + 1;
    b = e + $urandom_range(6, 30);
    push_ticks(e, b + 10 + PressLat - 1);
    push(1'b1, b + 10 + PressLat);
    e = b + 10 + PressLat + 1;
    m = e + $urandom_range(10, 25);
    push_ticks(e, m + 2);
    push(1'b1, m + SwLat);
    go(b - cyc);
    for (int unsigned i = 0; i < 10; i++) begin
      btn = ~btn;
      go(1);
    end
    btn = 1'b1;
    go(12);
    btn = 1'b0;
    go(m - cyc);
    switches = 2'b00;
    go(10);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
